hc_request_arbiter: RTL and testbench
=====================================

// Module: hc_request_arbiter
// PURPOSE
//  Shares the single HardCloud requestor (CCI-P read/write engine) between N_REQ requesters
//  (e.g. one per TX/RX buffer). Round-robin selects one pending t_request_control-style command,
//  forwards it downstream, then locks the grant until the requestor pulses done.
//  Sits between the user buffer logic and the requestor; gated by the HC_CONTROL start/stop level.
// PARAMETERS
//  N_REQ     2   number of requesters (>=2)
//  ID_W      2   request buffer-id width ($clog2(HC_BUFFER_SIZE)+1)
//  SIZE_W    32  request size width (HC_MAX_CMD_SIZE)
//  OFF_W     42  request offset width (t_ccip_clAddr, cache-line units)
// PORTS
//  clk         in   1              clock
//  reset       in   1              synchronous, active-high reset
//  enable      in   1              1 = new grants allowed (HC_CONTROL_START seen)
//  req_valid   in   N_REQ          per-requester command pending
//  req_cmd     in   3*N_REQ        t_request_cmd per requester, slice i = [3i+2:3i]
//  req_id      in   ID_W*N_REQ     buffer id per requester
//  req_size    in   SIZE_W*N_REQ   line count per requester
//  req_offset  in   OFF_W*N_REQ    line offset per requester
//  req_ready   out  N_REQ          one-cycle accept pulse, one-hot
//  out_valid   out  1              command to requestor valid
//  out_cmd     out  3              forwarded t_request_cmd
//  out_id      out  ID_W           forwarded id
//  out_size    out  SIZE_W         forwarded size
//  out_offset  out  OFF_W          forwarded offset
//  out_ready   in   1              requestor accepts command
//  done        in   1              requestor finished granted command (pulse)
//  busy        out  1              state != S_IDLE
//  grant_idx   out  $clog2(N_REQ)  index of current/last grant
//  served_cnt  out  16             completed commands, wraps at 2^16
//  drop_cnt    out  8              dropped illegal commands, saturates at 255
// BEHAVIOUR
//  Reset: state=S_IDLE; all outputs 0; last_grant = N_REQ-1 (so requester 0 is first in RR order).
//  States: S_IDLE -> S_ISSUE -> S_WAIT -> S_IDLE.
//  S_IDLE, enable=1: scan req_valid from last_grant+1 upward, wrapping; first set bit wins (w).
//    Legal cmd (1..4): latch cmd/id/size/offset into out_* regs, grant_idx=w, go S_ISSUE.
//    Illegal cmd (0 or 5..7): drop it; req_ready[w] pulses next cycle; drop_cnt++;
//      last_grant=w; stay S_IDLE. At most one drop per cycle.
//  S_IDLE, enable=0: no grant, no drop, req_ready=0.
//  req_ready[w] is registered: high exactly the cycle after the winning sample (first S_ISSUE
//    cycle for legal cmds). Requesters hold valid and data stable until they see ready.
//  S_ISSUE: out_valid=1, out_* stable. On out_valid&&out_ready go S_WAIT, out_valid=0 next cycle.
//  S_WAIT: hold until done=1; then last_grant=grant_idx, served_cnt++, go S_IDLE.
//  done outside S_WAIT is ignored. done in the same cycle as out_ready in S_ISSUE is ignored.
//  Latency: valid sampled at cycle t -> out_valid high at t+1.
//    done at cycle d -> S_IDLE at d+1 -> earliest next out_valid at d+2.
//  enable falling in S_ISSUE/S_WAIT does not abort; in-flight command completes normally.
//  Requester dropping valid after the grant sample does not cancel the latched command.
//  reset mid-operation: in-flight command abandoned; counters cleared; requestor must also reset.
//  busy = (state != S_IDLE); grant_idx holds its value in S_IDLE.
// TESTING
//  1 req0 valid, cmd=3 (READ_STREAM), id=1, size=16, off=0x100; out_ready=1, done 5 cycles later
//    -> out_valid at t+1 with those fields; req_ready[0] at t+1; served_cnt=1; busy low after done.
//  2 req0 and req1 valid continuously with legal cmds, immediate done
//    -> grants alternate 0,1,0,1; each out_valid exactly 2 cycles after the previous done.
//  3 req1 cmd=0 while req0 idle -> req_ready[1] one pulse, no out_valid, drop_cnt=1;
//    256 such drops -> drop_cnt stays 255.
//  4 out_ready held low 10 cycles in S_ISSUE -> out_valid and out_* stable all 10 cycles;
//    done pulses during S_ISSUE ignored.
//  5 enable=0 with req0 valid -> no grant. Raise enable -> grant next cycle.
//    Drop enable in S_WAIT -> done still returns to S_IDLE and served_cnt increments.
//  6 reset asserted in S_WAIT -> next cycle all outputs 0, state S_IDLE;
//    first grant after reset goes to requester 0.

Source files
------------

// File: rtl/hc_request_arbiter.sv
// hc_request_arbiter
// Round-robin arbiter sharing one HardCloud requestor between N_REQ command
// sources. A legal command is latched and presented downstream, then the
// grant is held until the requestor signals done. Illegal commands are
// acknowledged and dropped without reaching the requestor.
module hc_request_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ID_W   = 2,
    parameter int SIZE_W = 32,
    parameter int OFF_W  = 42
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [3*N_REQ-1:0]        req_cmd,
    input  logic [ID_W*N_REQ-1:0]     req_id,
    input  logic [SIZE_W*N_REQ-1:0]   req_size,
    input  logic [OFF_W*N_REQ-1:0]    req_offset,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [2:0]                out_cmd,
    output logic [ID_W-1:0]           out_id,
    output logic [SIZE_W-1:0]         out_size,
    output logic [OFF_W-1:0]          out_offset,
    input  logic                      out_ready,
    input  logic                      done,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_idx,
    output logic [15:0]               served_cnt,
    output logic [7:0]                drop_cnt
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Commands 1..4 are the only ones the requestor understands.
    function automatic logic cmd_legal(input logic [2:0] cmd);
        return (cmd >= 3'd1) && (cmd <= 3'd4);
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       last_grant_nxt;

    logic [N_REQ-1:0]    cand;
    logic                win_found;
    logic [GW-1:0]       win_idx;
    int                  scan_idx;
    logic [2:0]          win_cmd;
    logic [ID_W-1:0]     win_id;
    logic [SIZE_W-1:0]   win_size;
    logic [OFF_W-1:0]    win_offset;

    logic [N_REQ-1:0]    req_ready_nxt;
    logic                out_valid_nxt;
    logic [2:0]          out_cmd_nxt;
    logic [ID_W-1:0]     out_id_nxt;
    logic [SIZE_W-1:0]   out_size_nxt;
    logic [OFF_W-1:0]    out_offset_nxt;
    logic [GW-1:0]       grant_idx_nxt;
    logic [15:0]         served_cnt_nxt;
    logic [7:0]          drop_cnt_nxt;

    // A requester whose ready pulse is showing this cycle is still holding
    // its (already consumed) command; masking it stops a second accept.
    assign cand = req_valid & ~req_ready;

    // Round-robin scan starting just after the last serviced requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = {GW{1'b0}};
        scan_idx  = 32'sd0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = (int'(last_grant) + k) % N_REQ;
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = GW'(scan_idx);
            end else begin
                win_found = win_found;
            end
        end
    end

    // Select the winning requester's command fields.
    always_comb begin
        win_cmd    = req_cmd[3*int'(win_idx) +: 3];
        win_id     = req_id[ID_W*int'(win_idx) +: ID_W];
        win_size   = req_size[SIZE_W*int'(win_idx) +: SIZE_W];
        win_offset = req_offset[OFF_W*int'(win_idx) +: OFF_W];
    end

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        req_ready_nxt  = {N_REQ{1'b0}};
        out_valid_nxt  = out_valid;
        out_cmd_nxt    = out_cmd;
        out_id_nxt     = out_id;
        out_size_nxt   = out_size;
        out_offset_nxt = out_offset;
        grant_idx_nxt  = grant_idx;
        served_cnt_nxt = served_cnt;
        drop_cnt_nxt   = drop_cnt;

        case (state)
            S_IDLE: begin
                if (enable && win_found) begin
                    req_ready_nxt[win_idx] = 1'b1;
                    if (cmd_legal(win_cmd)) begin
                        out_valid_nxt  = 1'b1;
                        out_cmd_nxt    = win_cmd;
                        out_id_nxt     = win_id;
                        out_size_nxt   = win_size;
                        out_offset_nxt = win_offset;
                        grant_idx_nxt  = win_idx;
                        state_nxt      = S_ISSUE;
                    end else begin
                        // Dropped: advance RR pointer so others get a turn.
                        last_grant_nxt = win_idx;
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt_nxt = drop_cnt + 8'd1;
                        end else begin
                            drop_cnt_nxt = drop_cnt;
                        end
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                // done is meaningless before the requestor has the command.
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = S_WAIT;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (done) begin
                    last_grant_nxt = grant_idx;
                    served_cnt_nxt = served_cnt + 16'd1;
                    state_nxt      = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= GW'(N_REQ - 1);
            req_ready  <= {N_REQ{1'b0}};
            out_valid  <= 1'b0;
            out_cmd    <= 3'd0;
            out_id     <= {ID_W{1'b0}};
            out_size   <= {SIZE_W{1'b0}};
            out_offset <= {OFF_W{1'b0}};
            busy       <= 1'b0;
            grant_idx  <= {GW{1'b0}};
            served_cnt <= 16'd0;
            drop_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            req_ready  <= req_ready_nxt;
            out_valid  <= out_valid_nxt;
            out_cmd    <= out_cmd_nxt;
            out_id     <= out_id_nxt;
            out_size   <= out_size_nxt;
            out_offset <= out_offset_nxt;
            busy       <= (state_nxt != S_IDLE);
            grant_idx  <= grant_idx_nxt;
            served_cnt <= served_cnt_nxt;
            drop_cnt   <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hc_request_arbiter.sv
// Bench for hc_request_arbiter: cycle table plus directed multi-cycle sequences.
module tb_hc_request_arbiter;

    localparam int N_REQ  = 2;
    localparam int ID_W   = 2;
    localparam int SIZE_W = 32;
    localparam int OFF_W  = 42;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [N_REQ-1:0]         req_valid;
    logic [3*N_REQ-1:0]       req_cmd;
    logic [ID_W*N_REQ-1:0]    req_id;
    logic [SIZE_W*N_REQ-1:0]  req_size;
    logic [OFF_W*N_REQ-1:0]   req_offset;
    logic [N_REQ-1:0]         req_ready;
    logic                     out_valid;
    logic [2:0]               out_cmd;
    logic [ID_W-1:0]          out_id;
    logic [SIZE_W-1:0]        out_size;
    logic [OFF_W-1:0]         out_offset;
    logic                     out_ready;
    logic                     done;
    logic                     busy;
    logic [0:0]               grant_idx;
    logic [15:0]              served_cnt;
    logic [7:0]               drop_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Fixed per-requester payloads: req0 id=1 size=16 off=0x100, req1 id=2 size=32 off=0x200
    assign req_id     = {2'd2, 2'd1};
    assign req_size   = {32'd32, 32'd16};
    assign req_offset = {42'h200, 42'h100};

    always #5 clk = ~clk;

    hc_request_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .SIZE_W(SIZE_W), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_id(req_id),
        .req_size(req_size), .req_offset(req_offset), .req_ready(req_ready),
        .out_valid(out_valid), .out_cmd(out_cmd), .out_id(out_id),
        .out_size(out_size), .out_offset(out_offset), .out_ready(out_ready),
        .done(done), .busy(busy), .grant_idx(grant_idx),
        .served_cnt(served_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [1:0]  v;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        ordy;
        logic        dn;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic [2:0]  e_cmd;
        logic        e_busy;
        logic        e_gi;
        logic [15:0] e_srv;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl [30];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic en, input logic [1:0] v,
                         input logic [2:0] c0, input logic [2:0] c1,
                         input logic ordy, input logic dn);
        reset     = rst;
        enable    = en;
        req_valid = v;
        req_cmd   = {c1, c0};
        out_ready = ordy;
        done      = dn;
    endtask

    // Payload check for a forwarded command from requester gi.
    task automatic chk_payload(input string tag, input logic gi);
        chk({tag, "_id"},  64'(out_id),     gi ? 64'd2 : 64'd1);
        chk({tag, "_sz"},  64'(out_size),   gi ? 64'd32 : 64'd16);
        chk({tag, "_off"}, 64'(out_offset), gi ? 64'h200 : 64'h100);
    endtask

    initial begin
        // rst en v c0 c1 ordy dn | rdy ov cmd busy gi srv drop
        tbl[0]  = {1'b1,1'b0,2'b00,3'd0,3'd0,1'b0,1'b0, 2'b00,1'b0,3'd0,1'b0,1'b0,16'd0,8'd0};
        // single READ_STREAM from req0
        tbl[1]  = {1'b0,1'b1,2'b01,3'd3,3'd0,1'b1,1'b0, 2'b01,1'b1,3'd3,1'b1,1'b0,16'd0,8'd0};
        tbl[2]  = {1'b0,1'b1,2'b00,3'd3,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd3,1'b1,1'b0,16'd0,8'd0};
        tbl[3]  = {1'b0,1'b1,2'b00,3'd3,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd3,1'b1,1'b0,16'd0,8'd0};
        tbl[4]  = {1'b0,1'b1,2'b00,3'd3,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd3,1'b1,1'b0,16'd0,8'd0};
        tbl[5]  = {1'b0,1'b1,2'b00,3'd3,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd3,1'b1,1'b0,16'd0,8'd0};
        tbl[6]  = {1'b0,1'b1,2'b00,3'd3,3'd0,1'b1,1'b1, 2'b00,1'b0,3'd3,1'b0,1'b0,16'd1,8'd0};
        tbl[7]  = {1'b0,1'b1,2'b00,3'd3,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd3,1'b0,1'b0,16'd1,8'd0};
        // both requesting, immediate done: grants 1,0,1
        tbl[8]  = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b10,1'b1,3'd2,1'b1,1'b1,16'd1,8'd0};
        tbl[9]  = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd2,1'b1,1'b1,16'd1,8'd0};
        tbl[10] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd2,1'b0,1'b1,16'd2,8'd0};
        tbl[11] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b01,1'b1,3'd1,1'b1,1'b0,16'd2,8'd0};
        tbl[12] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd1,1'b1,1'b0,16'd2,8'd0};
        tbl[13] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd1,1'b0,1'b0,16'd3,8'd0};
        tbl[14] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b10,1'b1,3'd2,1'b1,1'b1,16'd3,8'd0};
        tbl[15] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd2,1'b1,1'b1,16'd3,8'd0};
        tbl[16] = {1'b0,1'b1,2'b11,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd2,1'b0,1'b1,16'd4,8'd0};
        // enable gating, enable dropped while waiting
        tbl[17] = {1'b0,1'b0,2'b01,3'd1,3'd2,1'b1,1'b0, 2'b00,1'b0,3'd2,1'b0,1'b1,16'd4,8'd0};
        tbl[18] = {1'b0,1'b0,2'b01,3'd1,3'd2,1'b1,1'b0, 2'b00,1'b0,3'd2,1'b0,1'b1,16'd4,8'd0};
        tbl[19] = {1'b0,1'b1,2'b01,3'd1,3'd2,1'b1,1'b0, 2'b01,1'b1,3'd1,1'b1,1'b0,16'd4,8'd0};
        tbl[20] = {1'b0,1'b0,2'b00,3'd1,3'd2,1'b1,1'b0, 2'b00,1'b0,3'd1,1'b1,1'b0,16'd4,8'd0};
        tbl[21] = {1'b0,1'b0,2'b00,3'd1,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd1,1'b0,1'b0,16'd5,8'd0};
        tbl[22] = {1'b0,1'b0,2'b01,3'd1,3'd2,1'b1,1'b0, 2'b00,1'b0,3'd1,1'b0,1'b0,16'd5,8'd0};
        // illegal command from req1 dropped once
        tbl[23] = {1'b0,1'b1,2'b10,3'd1,3'd0,1'b1,1'b0, 2'b10,1'b0,3'd1,1'b0,1'b0,16'd5,8'd1};
        tbl[24] = {1'b0,1'b1,2'b10,3'd1,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd1,1'b0,1'b0,16'd5,8'd1};
        tbl[25] = {1'b0,1'b1,2'b00,3'd1,3'd0,1'b1,1'b0, 2'b00,1'b0,3'd1,1'b0,1'b0,16'd5,8'd1};
        // req0 illegal (7) dropped, then req1 legal granted
        tbl[26] = {1'b0,1'b1,2'b11,3'd7,3'd2,1'b0,1'b0, 2'b01,1'b0,3'd1,1'b0,1'b0,16'd5,8'd2};
        tbl[27] = {1'b0,1'b1,2'b11,3'd7,3'd2,1'b0,1'b0, 2'b10,1'b1,3'd2,1'b1,1'b1,16'd5,8'd2};
        tbl[28] = {1'b0,1'b1,2'b00,3'd7,3'd2,1'b1,1'b0, 2'b00,1'b0,3'd2,1'b1,1'b1,16'd5,8'd2};
        tbl[29] = {1'b0,1'b1,2'b00,3'd7,3'd2,1'b1,1'b1, 2'b00,1'b0,3'd2,1'b0,1'b1,16'd6,8'd2};

        drive(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
        #2;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].c0, tbl[i].c1, tbl[i].ordy, tbl[i].dn);
            step();
            chk($sformatf("v%0d_rdy", i),  64'(req_ready),  64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_ov", i),   64'(out_valid),  64'(tbl[i].e_ov));
            chk($sformatf("v%0d_cmd", i),  64'(out_cmd),    64'(tbl[i].e_cmd));
            chk($sformatf("v%0d_busy", i), 64'(busy),       64'(tbl[i].e_busy));
            chk($sformatf("v%0d_gi", i),   64'(grant_idx),  64'(tbl[i].e_gi));
            chk($sformatf("v%0d_srv", i),  64'(served_cnt), 64'(tbl[i].e_srv));
            chk($sformatf("v%0d_drop", i), 64'(drop_cnt),   64'(tbl[i].e_drop));
            if (tbl[i].e_ov) begin
                chk_payload($sformatf("v%0d", i), tbl[i].e_gi);
            end
        end

        // Drop saturation: req1 keeps presenting illegal commands.
        begin
            logic ov_seen;
            ov_seen = 1'b0;
            drive(1'b0, 1'b1, 2'b10, 3'd1, 3'd0, 1'b0, 1'b0);
            step();
            chk("sat_first", 64'(drop_cnt), 64'd3);
            for (int i = 0; i < 600; i++) begin
                step();
                if (out_valid) ov_seen = 1'b1;
            end
            chk("sat_val", 64'(drop_cnt), 64'd255);
            chk("sat_noov", 64'(ov_seen), 64'd0);
            chk("sat_busy", 64'(busy), 64'd0);
            chk("sat_srv", 64'(served_cnt), 64'd6);
            drive(1'b0, 1'b1, 2'b00, 3'd1, 3'd0, 1'b0, 1'b0);
            step();
        end

        // Backpressure: out_ready low 10 cycles, done pulses in S_ISSUE ignored.
        drive(1'b0, 1'b1, 2'b01, 3'd4, 3'd0, 1'b0, 1'b0);
        step();
        chk("bp_ov0", 64'(out_valid), 64'd1);
        chk("bp_rdy", 64'(req_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 2'b00, 3'd4, 3'd0, 1'b0, (i % 2) == 0);
            step();
            chk($sformatf("bp%0d_ov", i),  64'(out_valid),  64'd1);
            chk($sformatf("bp%0d_cmd", i), 64'(out_cmd),    64'd4);
            chk_payload($sformatf("bp%0d", i), 1'b0);
            chk($sformatf("bp%0d_srv", i), 64'(served_cnt), 64'd6);
        end
        drive(1'b0, 1'b1, 2'b00, 3'd4, 3'd0, 1'b1, 1'b0);
        step();
        chk("bp_acc_ov", 64'(out_valid), 64'd0);
        chk("bp_acc_busy", 64'(busy), 64'd1);
        drive(1'b0, 1'b1, 2'b00, 3'd4, 3'd0, 1'b0, 1'b1);
        step();
        chk("bp_done_busy", 64'(busy), 64'd0);
        chk("bp_done_srv", 64'(served_cnt), 64'd7);

        // Reset during S_WAIT, then first grant must go to requester 0.
        drive(1'b0, 1'b1, 2'b10, 3'd1, 3'd3, 1'b1, 1'b0);
        step();
        chk("rs_gi", 64'(grant_idx), 64'd1);
        drive(1'b0, 1'b1, 2'b00, 3'd1, 3'd3, 1'b1, 1'b0);
        step();
        chk("rs_wait", 64'(busy), 64'd1);
        drive(1'b1, 1'b1, 2'b00, 3'd1, 3'd3, 1'b1, 1'b0);
        step();
        chk("rs_rdy",  64'(req_ready),  64'd0);
        chk("rs_ov",   64'(out_valid),  64'd0);
        chk("rs_cmd",  64'(out_cmd),    64'd0);
        chk("rs_id",   64'(out_id),     64'd0);
        chk("rs_size", 64'(out_size),   64'd0);
        chk("rs_off",  64'(out_offset), 64'd0);
        chk("rs_busy", 64'(busy),       64'd0);
        chk("rs_gi0",  64'(grant_idx),  64'd0);
        chk("rs_srv",  64'(served_cnt), 64'd0);
        chk("rs_drop", 64'(drop_cnt),   64'd0);
        drive(1'b0, 1'b1, 2'b11, 3'd1, 3'd2, 1'b0, 1'b0);
        step();
        chk("rs_first_rdy", 64'(req_ready), 64'd1);
        chk("rs_first_gi",  64'(grant_idx), 64'd0);
        chk("rs_first_ov",  64'(out_valid), 64'd1);
        chk("rs_first_cmd", 64'(out_cmd),   64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
